// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Frame sequencer in front of the Matrix_Mul fixed-point matrix-vector
// multiplier. A frame of N*N matrix words (row-major) followed by N vector
// words is written to multiplier addresses 0..N*N+N-1. The controller then
// waits out the compute latency, captures the N result elements together with
// their QI/QF tags into a local buffer and drains them on a valid/ready stream.
//
// Build option: define MM_SEQ_PERF_EN to add the perf_cycles output, which
// reports the cycle count of the most recently completed frame.
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDRS_LEN   = 7,
  parameter int N           = 8,
  parameter int FIRST_LAT   = 64,
  parameter int ELEM_PERIOD = 2
) (
  input  logic                 src_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 mm_we,
  output logic [ADDRS_LEN-1:0] mm_addr,
  output logic [WORD_SIZE-1:0] mm_data_wr,
  input  logic [WORD_SIZE-1:0] mm_result,
  input  logic [3:0]           mm_qi,
  input  logic [3:0]           mm_qf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [3:0]           out_qi,
  output logic [3:0]           out_qf,
  output logic                 out_last,
  output logic                 busy,
  output logic [15:0]          frame_cnt
`ifdef MM_SEQ_PERF_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);

  // ---------------------------------------------------------------------------
  // Derived sizes and constants
  // ---------------------------------------------------------------------------
  localparam int FRAME_LEN = N * N + N;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam int WAIT_W    = (FIRST_LAT > 2) ? $clog2(FIRST_LAT - 1) : 1;
  localparam int PH_W      = (ELEM_PERIOD > 1) ? $clog2(ELEM_PERIOD) : 1;
  localparam int ELEM_W    = WORD_SIZE + 8;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(N - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  // WAIT spans FIRST_LAT-1 cycles: counter values 0..FIRST_LAT-2.
  localparam logic [WAIT_W-1:0] WAIT_END  = WAIT_W'(FIRST_LAT - 2);
  localparam logic [PH_W-1:0]   PH_ZERO   = PH_W'(0);
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0]   PH_END    = PH_W'(ELEM_PERIOD - 1);

  // Parameter sanity: the frame must fit the multiplier address space.
  generate
    if (N * N + N > 2 ** ADDRS_LEN) begin : g_bad_addr_space
      $error("matmul_seq_ctrl: N*N+N exceeds the 2**ADDRS_LEN address space");
    end
    if (N < 2 || FIRST_LAT < 2 || ELEM_PERIOD < 1) begin : g_bad_timing
      $error("matmul_seq_ctrl: need N>=2, FIRST_LAT>=2, ELEM_PERIOD>=1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Multiplier address is the word count truncated to the address width.
  function automatic logic [ADDRS_LEN-1:0] cnt_to_addr(input logic [CNT_W-1:0] cnt);
    return ADDRS_LEN'(cnt);
  endfunction

`ifdef MM_SEQ_PERF_EN
  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : (value + 16'd1);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;

  logic                   in_ready_r;
  logic                   mm_we_r;
  logic [ADDRS_LEN-1:0]   mm_addr_r;
  logic [WORD_SIZE-1:0]   mm_data_wr_r;
  logic                   out_valid_r;
  logic [WORD_SIZE-1:0]   out_data_r;
  logic [3:0]             out_qi_r;
  logic [3:0]             out_qf_r;
  logic                   out_last_r;
  logic                   busy_r;
  logic [15:0]            frame_cnt_r;
  logic [CNT_W-1:0]       word_cnt_r;
  logic [CNT_W-1:0]       elem_cnt_r;
  logic [WAIT_W-1:0]      wait_cnt_r;
  logic [PH_W-1:0]        ph_r;

  logic                   in_ready_next_s;
  logic                   mm_we_next_s;
  logic [ADDRS_LEN-1:0]   mm_addr_next_s;
  logic [WORD_SIZE-1:0]   mm_data_wr_next_s;
  logic                   out_valid_next_s;
  logic [WORD_SIZE-1:0]   out_data_next_s;
  logic [3:0]             out_qi_next_s;
  logic [3:0]             out_qf_next_s;
  logic                   out_last_next_s;
  logic [15:0]            frame_cnt_next_s;
  logic [CNT_W-1:0]       word_cnt_next_s;
  logic [CNT_W-1:0]       elem_cnt_next_s;
  logic [WAIT_W-1:0]      wait_cnt_next_s;
  logic [PH_W-1:0]        ph_next_s;

  logic                   accept_s;
  logic                   buf_we_s;
  logic [IDX_W-1:0]       wr_idx_s;
  logic [IDX_W-1:0]       rd_idx_s;
  logic [ELEM_W-1:0]      capture_s;
  logic [ELEM_W-1:0]      rd_word_s;

  // Result buffer: {result, qi, qf} per element; not reset, only presented
  // after a full capture pass has refilled it.
  logic [ELEM_W-1:0]      buf_r [N];

`ifdef MM_SEQ_PERF_EN
  logic [15:0]            perf_cnt_r;
  logic [15:0]            perf_cycles_r;
  logic [15:0]            perf_cnt_next_s;
  logic [15:0]            perf_cycles_next_s;
`endif

  assign accept_s  = in_valid && in_ready_r;
  assign capture_s = {mm_result, mm_qi, mm_qf};
  assign wr_idx_s  = IDX_W'(elem_cnt_r);
  assign rd_word_s = buf_r[rd_idx_s];

  // Buffer read index: slot 0 while capturing (first presented element),
  // the following slot while draining.
  always_comb begin
    rd_idx_s = {IDX_W{1'b0}};
    if (state_r == ST_DRAIN) begin
      rd_idx_s = IDX_W'(elem_cnt_r + CNT_ONE);
    end else begin
      rd_idx_s = {IDX_W{1'b0}};
    end
  end

  // Next-state and next-register decode; every output is registered from it.
  always_comb begin
    state_next_s      = state_r;
    in_ready_next_s   = 1'b0;
    mm_we_next_s      = 1'b0;
    mm_addr_next_s    = mm_addr_r;
    mm_data_wr_next_s = mm_data_wr_r;
    out_valid_next_s  = out_valid_r;
    out_data_next_s   = out_data_r;
    out_qi_next_s     = out_qi_r;
    out_qf_next_s     = out_qf_r;
    out_last_next_s   = out_last_r;
    frame_cnt_next_s  = frame_cnt_r;
    word_cnt_next_s   = word_cnt_r;
    elem_cnt_next_s   = elem_cnt_r;
    wait_cnt_next_s   = wait_cnt_r;
    ph_next_s         = ph_r;
    buf_we_s          = 1'b0;
`ifdef MM_SEQ_PERF_EN
    perf_cnt_next_s    = perf_cnt_r;
    perf_cycles_next_s = perf_cycles_r;
`endif

    case (state_r)
      ST_IDLE: begin
        in_ready_next_s = 1'b1;
        if (accept_s) begin
          mm_we_next_s      = 1'b1;
          mm_addr_next_s    = {ADDRS_LEN{1'b0}};
          mm_data_wr_next_s = in_data;
          word_cnt_next_s   = CNT_ONE;
          state_next_s      = ST_LOAD;
        end else begin
          word_cnt_next_s   = CNT_ZERO;
        end
      end

      ST_LOAD: begin
        in_ready_next_s = 1'b1;
        if (accept_s) begin
          mm_we_next_s      = 1'b1;
          mm_addr_next_s    = cnt_to_addr(word_cnt_r);
          mm_data_wr_next_s = in_data;
          word_cnt_next_s   = word_cnt_r + CNT_ONE;
          if (word_cnt_r == LAST_WORD) begin
            in_ready_next_s = 1'b0;
            state_next_s    = ST_SETTLE;
          end else begin
            state_next_s    = ST_LOAD;
          end
        end else begin
          // Gap on in_valid: no write, address holds.
          mm_we_next_s = 1'b0;
        end
      end

      ST_SETTLE: begin
        word_cnt_next_s = CNT_ZERO;
        wait_cnt_next_s = WAIT_ZERO;
        state_next_s    = ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_cnt_r == WAIT_END) begin
          ph_next_s       = PH_ZERO;
          elem_cnt_next_s = CNT_ZERO;
          state_next_s    = ST_CAPTURE;
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
        end
      end

      ST_CAPTURE: begin
        ph_next_s = (ph_r == PH_END) ? PH_ZERO : (ph_r + PH_ONE);
        if (ph_r == PH_ZERO) begin
          buf_we_s = 1'b1;
          if (elem_cnt_r == LAST_ELEM) begin
            // Last slot lands this edge; slot 0 is already stable to present.
            elem_cnt_next_s  = CNT_ZERO;
            out_valid_next_s = 1'b1;
            out_data_next_s  = rd_word_s[ELEM_W-1:8];
            out_qi_next_s    = rd_word_s[7:4];
            out_qf_next_s    = rd_word_s[3:0];
            out_last_next_s  = 1'b0;
            state_next_s     = ST_DRAIN;
          end else begin
            elem_cnt_next_s  = elem_cnt_r + CNT_ONE;
          end
        end else begin
          buf_we_s = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (out_valid_r && out_ready) begin
          if (elem_cnt_r == LAST_ELEM) begin
            out_valid_next_s = 1'b0;
            out_last_next_s  = 1'b0;
            elem_cnt_next_s  = CNT_ZERO;
            frame_cnt_next_s = frame_cnt_r + 16'd1;
            in_ready_next_s  = 1'b1;
            state_next_s     = ST_IDLE;
`ifdef MM_SEQ_PERF_EN
            // Count including this final handshake cycle.
            perf_cycles_next_s = sat_inc16(perf_cnt_r);
`endif
          end else begin
            elem_cnt_next_s  = elem_cnt_r + CNT_ONE;
            out_data_next_s  = rd_word_s[ELEM_W-1:8];
            out_qi_next_s    = rd_word_s[7:4];
            out_qf_next_s    = rd_word_s[3:0];
            out_last_next_s  = ((elem_cnt_r + CNT_ONE) == LAST_ELEM);
          end
        end else begin
          // Stalled: presented element stays frozen.
          out_valid_next_s = out_valid_r;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

`ifdef MM_SEQ_PERF_EN
    if (state_r == ST_IDLE) begin
      if (accept_s) begin
        perf_cnt_next_s = 16'd1;
      end else begin
        perf_cnt_next_s = perf_cnt_r;
      end
    end else begin
      perf_cnt_next_s = sat_inc16(perf_cnt_r);
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs and sequencing counters.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      in_ready_r   <= 1'b0;
      mm_we_r      <= 1'b0;
      mm_addr_r    <= {ADDRS_LEN{1'b0}};
      mm_data_wr_r <= {WORD_SIZE{1'b0}};
      out_valid_r  <= 1'b0;
      out_data_r   <= {WORD_SIZE{1'b0}};
      out_qi_r     <= 4'd0;
      out_qf_r     <= 4'd0;
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      frame_cnt_r  <= 16'd0;
      word_cnt_r   <= CNT_ZERO;
      elem_cnt_r   <= CNT_ZERO;
      wait_cnt_r   <= WAIT_ZERO;
      ph_r         <= PH_ZERO;
    end else begin
      in_ready_r   <= in_ready_next_s;
      mm_we_r      <= mm_we_next_s;
      mm_addr_r    <= mm_addr_next_s;
      mm_data_wr_r <= mm_data_wr_next_s;
      out_valid_r  <= out_valid_next_s;
      out_data_r   <= out_data_next_s;
      out_qi_r     <= out_qi_next_s;
      out_qf_r     <= out_qf_next_s;
      out_last_r   <= out_last_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
      frame_cnt_r  <= frame_cnt_next_s;
      word_cnt_r   <= word_cnt_next_s;
      elem_cnt_r   <= elem_cnt_next_s;
      wait_cnt_r   <= wait_cnt_next_s;
      ph_r         <= ph_next_s;
    end
  end

  // Result capture into the element buffer.
  always_ff @(posedge src_clk) begin
    if (buf_we_s) begin
      buf_r[wr_idx_s] <= capture_s;
    end
  end

`ifdef MM_SEQ_PERF_EN
  // Frame cycle counter and the latched per-frame result.
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      perf_cnt_r    <= 16'd0;
      perf_cycles_r <= 16'd0;
    end else begin
      perf_cnt_r    <= perf_cnt_next_s;
      perf_cycles_r <= perf_cycles_next_s;
    end
  end

  assign perf_cycles = perf_cycles_r;
`endif

  assign in_ready   = in_ready_r;
  assign mm_we      = mm_we_r;
  assign mm_addr    = mm_addr_r;
  assign mm_data_wr = mm_data_wr_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_qi     = out_qi_r;
  assign out_qf     = out_qf_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;
  assign frame_cnt  = frame_cnt_r;

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer in front of the fixed-point matrix-vector multiplier (Matrix_Mul).
- Accepts a frame of 64 matrix words followed by 8 vector words on a valid/ready stream. Writes them to the multiplier's address space 0..71 using we/addr/data_wr, then waits out the compute latency.
- Captures the 8 result elements with their QI/QF format tags into a local buffer and drains them on a valid/ready output stream.
- Replaces the free-running timed load/capture currently hand-coded in benches.

Parameters:
- WORD_SIZE, 16, data word width; must match the multiplier.
- ADDRS_LEN, 7, multiplier address width.
- N, 8, vector length; matrix is N*N words; frame is N*N+N words.
- FIRST_LAT, 64, cycles from the we falling edge to the first valid result element on mm_result.
- ELEM_PERIOD, 2, cycles between successive result elements.

Ports:
- src_clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller accepts in_data this cycle
- in_data  in  WORD_SIZE  matrix/vector word; row-major matrix first, then vector
- mm_we  out  1  multiplier write enable
- mm_addr  out  ADDRS_LEN  multiplier write address
- mm_data_wr  out  WORD_SIZE  multiplier write data
- mm_result  in  WORD_SIZE  multiplier AB_Transpose element (signed)
- mm_qi  in  4  multiplier integer-bit count
- mm_qf  in  4  multiplier fraction-bit count
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts result
- out_data  out  WORD_SIZE  result element
- out_qi  out  4  QI of the element
- out_qf  out  4  QF of the element
- out_last  out  1  high with element N-1
- busy  out  1  high in any state other than IDLE
- frame_cnt  out  16  number of completed frames; wraps at 65535 to 0

Behaviour:
- Reset values: in_ready=0, mm_we=0, mm_addr=0, mm_data_wr=0, out_valid=0, out_data=0, out_qi=0, out_qf=0, out_last=0, busy=0, frame_cnt=0, state=IDLE. Reset is asynchronous and abandons any frame in progress; buffer contents are not cleared but are never presented.
- IDLE:
  - in_ready=1.
  - The first in_valid&&in_ready goes to LOAD. That word is registered with mm_addr=0 and mm_we=1.
- LOAD:
  - in_ready=1. Each accepted word is registered to mm_data_wr; mm_addr equals the word index (0..N*N+N-1).
  - mm_we is high only in the cycle after an accept. Gaps on in_valid drop mm_we for those cycles, and mm_addr holds.
  - After word N*N+N-1 is accepted: in_ready=0 next cycle, go to SETTLE.
- SETTLE: one cycle with mm_we=0, mm_addr held; load counter cleared; go to WAIT.
- WAIT:
  - Counts FIRST_LAT-1 cycles, then goes to CAPTURE.
  - No input is accepted; words offered here stall (in_ready=0).
- CAPTURE:
  - Samples {mm_result, mm_qi, mm_qf} into buffer slot k on entry and every ELEM_PERIOD cycles thereafter, k=0..N-1.
  - After slot N-1 is sampled, go to DRAIN.
- DRAIN:
  - Presents slot j with out_valid=1 and out_last=(j==N-1). Elements are registered outputs and are stable while out_valid&&!out_ready.
  - Each handshake advances j. On the handshake of j=N-1: out_valid=0, frame_cnt+=1, go to IDLE.
  - in_ready is 0 throughout DRAIN; frames never overlap.
- out_ready held low indefinitely: the controller stays in DRAIN with outputs frozen.
- out_ready is ignored while out_valid=0.
- Word and element counters are sized to ceil(log2(N*N+N+1)); mm_addr is that count truncated to ADDRS_LEN. Elaboration must fail if N*N+N > 2**ADDRS_LEN.

Optional Feature:
- Macro MM_SEQ_PERF_EN.
- Defined:
  - Adds output port perf_cycles (16 bits), reset 0.
  - An internal counter starts at 1 in the cycle of the first accept of a frame and increments every cycle, saturating at 65535.
  - On the final DRAIN handshake, perf_cycles is loaded with the counter value; it holds until the next frame completes.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-LOAD:
  - Stimulus: assert rst after word 30.
  - Required: mm_we=0, busy=0 and in_ready=0 immediately (asynchronous); in_ready=1 after release.
  - Required: a full new frame then writes addresses 0..71 in order.
- Back-to-back load:
  - Stimulus: in_valid held high, words 0x0000..0x0047.
  - Required: mm_addr/mm_data_wr pairs (0,0x0000)..(71,0x0047) on 72 consecutive cycles, then mm_we=0; busy=1 from the first accept.
- Gapped load:
  - Stimulus: in_valid toggling 1/0.
  - Required: mm_we pulses only after accepts; mm_addr holds during gaps; 72 writes total, none duplicated.
- Capture timing:
  - Stimulus: a model multiplier drives mm_result=0x0100+k, QI=4, QF=4, valid from cycle FIRST_LAT after we falls with element k held ELEM_PERIOD cycles.
  - Required: out_data 0x0100..0x0107, each with out_qi=4, out_qf=4; out_last only on 0x0107.
- Output backpressure:
  - Stimulus: out_ready=0 for 20 cycles in DRAIN, then 1 on alternate cycles.
  - Required: out_data stable while stalled; all 8 elements delivered exactly once; in_ready=0 until the last handshake; frame_cnt 0->1.
- Perf and wrap (MM_SEQ_PERF_EN defined):
  - Required: back-to-back load with out_ready=1 gives perf_cycles = 72+1+FIRST_LAT+(N-1)*ELEM_PERIOD+N.
  - Required: frame_cnt preloaded via force to 65535 wraps to 0 after one frame.
